// File: rtl/nn_node_pkg.sv
`default_nettype none
// ============================================================================
// Module   : nn_node_pkg
// Brief    : Shared mode constants and signed clamp helper for the polar
//            stochastic tanh node.
// Revision : 1.0
// ============================================================================
package nn_node_pkg;

  localparam int MODE_OR  = 0;
  localparam int MODE_SUM = 1;

  function automatic int sat_clamp(input int v, input int lo, input int hi);
    if (v < lo)
      return lo;
    else if (v > hi)
      return hi;
    else
      return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/nn_sat_counter.sv
`default_nettype none
// ============================================================================
// Module   : nn_sat_counter
// Brief    : Saturating up/down state counter with upper-half threshold output.
// Revision : 1.0
// ============================================================================
module nn_sat_counter
  import nn_node_pkg::*;
#(
  parameter int STATES = 16,
  parameter int SW     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic signed [SW-1:0] i_step,
  output logic                 o_a_next,
  output logic                 o_a_out
);

  localparam int SBW = $clog2(STATES);
  localparam logic [SBW-1:0] C_MID = SBW'(STATES / 2);

  logic [SBW-1:0] r_state;
  logic [SBW-1:0] w_state_next;
  int             w_sum;

  // Clamp in full int range so large negative steps never wrap the state.
  always_comb begin
    w_sum        = sat_clamp(int'(r_state) + int'(i_step), 0, STATES - 1);
    w_state_next = SBW'(w_sum);
    o_a_next     = (w_state_next >= C_MID);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= C_MID;
      o_a_out <= 1'b0;
    end else if (i_en) begin
      r_state <= w_state_next;
      o_a_out <= o_a_next;
    end
  end

endmodule
`default_nettype wire

// File: rtl/nn_node_polar_stanh.sv
`default_nettype none
// ============================================================================
// Module   : nn_node_polar_stanh
// Brief    : Polar stochastic neuron: signed weight/bias combine, saturating
//            tanh FSM activation and windowed ones-count estimator.
// Revision : 1.0
// ============================================================================
module nn_node_polar_stanh
  import nn_node_pkg::*;
#(
  parameter int N      = 4,
  parameter int STATES = 16,
  parameter int MODE   = 0,
  parameter int WIN    = 256
) (
  input  logic                       CLK,
  input  logic                       INIT,
  input  logic                       EN,
  input  logic [N-1:0]               a,
  input  logic [N-1:0]               alpha,
  input  logic [N-1:0]               SIGN_alpha,
  input  logic                       beta,
  input  logic                       SIGN_beta,
  output logic                       z,
  output logic                       a_out,
  output logic [$clog2(WIN+1)-1:0]   win_count,
  output logic                       win_valid
);

  localparam int SW = $clog2(N + 2) + 1;
  localparam int CW = $clog2(WIN);
  localparam int OW = $clog2(WIN + 1);
  localparam logic [CW-1:0] C_LAST = CW'(WIN - 1);

  logic [N:0]           w_pos;
  logic [N:0]           w_neg;
  logic                 w_zpos;
  logic                 w_zneg;
  logic signed [SW-1:0] w_step;
  logic                 w_a_next;
  logic [OW-1:0]        w_ones_next;

  logic [CW-1:0]        r_cyc;
  logic [OW-1:0]        r_ones;

  // Bias occupies the top bit of each polarity set.
  assign w_pos  = {beta & ~SIGN_beta, a & alpha & ~SIGN_alpha};
  assign w_neg  = {beta &  SIGN_beta, a & alpha &  SIGN_alpha};
  assign w_zpos = |w_pos;
  assign w_zneg = |w_neg;
  assign z      = w_zpos & ~w_zneg;

  if (MODE == MODE_SUM) begin : g_mode_sum
    int w_npos;
    int w_nneg;
    always_comb begin
      w_npos = 0;
      w_nneg = 0;
      for (int i = 0; i <= N; i++) begin
        w_npos += int'(w_pos[i]);
        w_nneg += int'(w_neg[i]);
      end
      w_step = SW'(w_npos - w_nneg);
    end
  end else begin : g_mode_or
    always_comb begin
      w_step = SW'(0);
      if (w_zpos & ~w_zneg)
        w_step = SW'(1);
      else if (w_zneg & ~w_zpos)
        w_step = SW'(-1);
    end
  end

  nn_sat_counter #(
    .STATES (STATES),
    .SW     (SW)
  ) u_sat_counter (
    .clk      (CLK),
    .rst_n    (INIT),
    .i_en     (EN),
    .i_step   (w_step),
    .o_a_next (w_a_next),
    .o_a_out  (a_out)
  );

  assign w_ones_next = r_ones + OW'(w_a_next);

  // The closing cycle's own activation bit is folded into the published count.
  always_ff @(posedge CLK or negedge INIT) begin
    if (!INIT) begin
      r_cyc     <= '0;
      r_ones    <= '0;
      win_count <= '0;
      win_valid <= 1'b0;
    end else begin
      win_valid <= 1'b0;
      if (EN) begin
        if (r_cyc == C_LAST) begin
          win_count <= w_ones_next;
          win_valid <= 1'b1;
          r_cyc     <= '0;
          r_ones    <= '0;
        end else begin
          r_cyc  <= r_cyc + 1'b1;
          r_ones <= w_ones_next;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_nn_node_polar_stanh.sv
`default_nettype none
// ============================================================================
// Module   : tb_nn_node_polar_stanh
// Brief    : Self-checking bench for both combine modes (N=4, STATES=16, WIN=16).
// Revision : 1.0
// ============================================================================
module tb_nn_node_polar_stanh;

  logic       CLK = 1'b0;
  logic       INIT = 1'b0;
  logic       EN = 1'b0;
  logic [3:0] a = '0;
  logic [3:0] alpha = '0;
  logic [3:0] sa = '0;
  logic       beta = 1'b0;
  logic       sb = 1'b0;

  logic       z0, z1, ao0, ao1, wv0, wv1;
  logic [4:0] wc0, wc1;

  always #5 CLK = ~CLK;

  nn_node_polar_stanh #(.N(4), .STATES(16), .MODE(0), .WIN(16)) u_or (
    .CLK(CLK), .INIT(INIT), .EN(EN), .a(a), .alpha(alpha), .SIGN_alpha(sa),
    .beta(beta), .SIGN_beta(sb), .z(z0), .a_out(ao0), .win_count(wc0), .win_valid(wv0)
  );

  nn_node_polar_stanh #(.N(4), .STATES(16), .MODE(1), .WIN(16)) u_sum (
    .CLK(CLK), .INIT(INIT), .EN(EN), .a(a), .alpha(alpha), .SIGN_alpha(sa),
    .beta(beta), .SIGN_beta(sb), .z(z1), .a_out(ao1), .win_count(wc1), .win_valid(wv1)
  );

  int   n_tests = 0;
  int   n_fail = 0;
  int   ms[2];
  int   mcyc[2];
  int   mones[2];
  int   mwc[2];
  logic ma[2];
  logic mwv[2];

  typedef struct {
    logic       rst;
    logic [3:0] va;
    logic [3:0] val;
    logic [3:0] vsa;
    logic       vb;
    logic       vsb;
    logic       ven;
    logic       ez;
    logic       ea0;
    logic       ea1;
  } vec_t;

  vec_t tbl[15];

  task automatic chk(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Count members of the positive (neg=0) or negative (neg=1) polarity set.
  function automatic int pcount(input logic neg);
    int c = 0;
    for (int i = 0; i < 4; i++)
      if (a[i] && alpha[i] && (sa[i] == neg)) c++;
    if (beta && (sb == neg)) c++;
    return c;
  endfunction

  function automatic int mstep(input int m);
    int p = pcount(1'b0);
    int n = pcount(1'b1);
    if (m == 1) return p - n;
    if (p > 0 && n == 0) return 1;
    if (n > 0 && p == 0) return -1;
    return 0;
  endfunction

  task automatic model_reset();
    for (int m = 0; m < 2; m++) begin
      ms[m] = 8; ma[m] = 1'b0; mcyc[m] = 0; mones[m] = 0; mwc[m] = 0; mwv[m] = 1'b0;
    end
  endtask

  task automatic model_edge();
    int ns;
    for (int m = 0; m < 2; m++) begin
      mwv[m] = 1'b0;
      if (EN) begin
        ns = ms[m] + mstep(m);
        if (ns < 0) ns = 0;
        if (ns > 15) ns = 15;
        ms[m] = ns;
        ma[m] = (ns >= 8);
        mones[m] += int'(ma[m]);
        if (mcyc[m] == 15) begin
          mwc[m] = mones[m]; mwv[m] = 1'b1; mcyc[m] = 0; mones[m] = 0;
        end else begin
          mcyc[m]++;
        end
      end
    end
  endtask

  task automatic check_outs(input string tag);
    chk({tag, "_aout_or"}, ao0, ma[0]);
    chk({tag, "_aout_sum"}, ao1, ma[1]);
    chk({tag, "_wcount_or"}, wc0, mwc[0]);
    chk({tag, "_wcount_sum"}, wc1, mwc[1]);
    chk({tag, "_wvalid_or"}, wv0, mwv[0]);
    chk({tag, "_wvalid_sum"}, wv1, mwv[1]);
  endtask

  // Drive one vector, check z before the edge and registered outputs after it.
  task automatic apply(input logic [3:0] ia, input logic [3:0] ial, input logic [3:0] isa,
                       input logic ib, input logic isb, input logic ien);
    logic ez;
    a = ia; alpha = ial; sa = isa; beta = ib; sb = isb; EN = ien;
    #1;
    ez = (pcount(1'b0) > 0) && (pcount(1'b1) == 0);
    chk("z_or", z0, ez);
    chk("z_sum", z1, ez);
    @(posedge CLK);
    model_edge();
    #1;
    check_outs("cyc");
  endtask

  // Asynchronous assertion between edges; outputs must clear before the next edge.
  task automatic do_reset();
    #2;
    INIT = 1'b0;
    #1;
    model_reset();
    check_outs("rst");
    #1;
    INIT = 1'b1;
  endtask

  int pulses;
  int pulse_at;
  int wcap;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{1'b1, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    for (int i = 1; i < 8; i++)
      tbl[i] = '{1'b0, 4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    tbl[8]  = '{1'b1, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[9]  = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[10] = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[11] = '{1'b1, 4'hF, 4'hF, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[12] = '{1'b0, 4'hF, 4'hF, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[13] = '{1'b0, 4'hF, 4'hF, 4'h3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    tbl[14] = '{1'b0, 4'hF, 4'hF, 4'hF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};

    #1;
    model_reset();
    check_outs("init");
    #1;
    INIT = 1'b1;

    for (int i = 0; i < 15; i++) begin
      if (tbl[i].rst) do_reset();
      apply(tbl[i].va, tbl[i].val, tbl[i].vsa, tbl[i].vb, tbl[i].vsb, tbl[i].ven);
      chk("tbl_z", z0, tbl[i].ez);
      chk("tbl_aout_or", ao0, tbl[i].ea0);
      chk("tbl_aout_sum", ao1, tbl[i].ea1);
    end

    // Full window of ones with EN held high.
    do_reset();
    pulses = 0; pulse_at = 0; wcap = 0;
    for (int c = 1; c <= 17; c++) begin
      apply(4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
      if (wv0) begin pulses++; pulse_at = c; wcap = int'(wc0); end
    end
    chk("win_full_pulses", pulses, 1);
    chk("win_full_at", pulse_at, 16);
    chk("win_full_count", wcap, 16);

    // EN toggling: window closes on the 16th enabled edge.
    do_reset();
    pulses = 0; pulse_at = 0; wcap = 0;
    for (int c = 1; c <= 32; c++) begin
      apply(4'hF, 4'hF, 4'h0, 1'b0, 1'b0, logic'(c % 2 == 0));
      if (wv0) begin pulses++; pulse_at = c; wcap = int'(wc0); end
    end
    chk("win_toggle_pulses", pulses, 1);
    chk("win_toggle_at", pulse_at, 32);
    chk("win_toggle_count", wcap, 16);

    // Reset mid-window discards the partial window.
    do_reset();
    pulses = 0; pulse_at = 0;
    for (int c = 1; c <= 10; c++) begin
      apply(4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
      if (wv0) pulses++;
    end
    do_reset();
    for (int c = 1; c <= 16; c++) begin
      apply(4'hF, 4'hF, 4'h0, 1'b0, 1'b0, 1'b1);
      if (wv0) begin pulses++; pulse_at = c; end
    end
    chk("win_abort_pulses", pulses, 1);
    chk("win_abort_at", pulse_at, 16);

    // Randomised traffic against the reference model.
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      apply(4'($urandom), 4'($urandom), 4'($urandom), 1'($urandom), 1'($urandom),
            logic'($urandom_range(0, 3) != 0));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/nn_node_polar_stanh.md
NN_NODE_POLAR_STANH -- requirements
Module: nn_node_polar_stanh

Interface
REQ-001 Parameter N, default 4, number of stochastic inputs (1..32).
REQ-002 Parameter STATES, default 16, activation FSM depth (power of 2, 4..256).
REQ-003 Parameter MODE, default 0: 0 = OR-combine (saturating), 1 = popcount-sum (linear).
REQ-004 Parameter WIN, default 256, output-estimate window in enabled cycles (2..65535).
REQ-005 CLK  in  1  single clock; all state updates on rising edge.
REQ-006 INIT  in  1  reset, asynchronous assert, active-low.
REQ-007 EN  in  1  advance enable; low freezes all state.
REQ-008 a  in  N  stochastic activation bitstreams.
REQ-009 alpha  in  N  weight-magnitude bitstreams.
REQ-010 SIGN_alpha  in  N  weight sign per input, 1 = negative.
REQ-011 beta  in  1  bias-magnitude bitstream.
REQ-012 SIGN_beta  in  1  bias sign, 1 = negative.
REQ-013 z  out  1  combinational net-sign bit, z_pos & ~z_neg.
REQ-014 a_out  out  1  registered activation bitstream.
REQ-015 win_count  out  clog2(WIN+1)  ones in a_out over last completed window.
REQ-016 win_valid  out  1  one-cycle pulse when win_count updates.

Function
REQ-017 Per input n: pos[n] = a&alpha&~SIGN_alpha, neg[n] = a&alpha&SIGN_alpha; bias adds beta&~SIGN_beta to pos set, beta&SIGN_beta to neg set (N+1 terms each).
REQ-018 z_pos = OR(pos set), z_neg = OR(neg set), z = z_pos & ~z_neg, for both modes.
REQ-019 MODE 0 step: +1 if z_pos&~z_neg, -1 if z_neg&~z_pos, else 0.
REQ-020 MODE 1 step: popcount(pos set) - popcount(neg set), signed, range -(N+1)..+(N+1), no truncation.
REQ-021 State S in 0..STATES-1; on EN=1, S <= clamp(S+step, 0, STATES-1); overshoot clamps, never wraps.
REQ-022 a_out <= (S_next >= STATES/2) on EN=1; one-cycle latency from inputs to a_out.
REQ-023 EN=0: S, a_out, window counters hold; z still combinational.
REQ-024 Window: cycle counter counts enabled cycles 0..WIN-1; ones counter adds new a_out value each enabled cycle.
REQ-025 On enabled cycle where cycle counter = WIN-1: win_count <= ones including that cycle's a_out, win_valid = 1 next cycle only, both counters restart at 0 same edge.
REQ-026 win_valid low at all other times, including while EN=0.
REQ-027 ones counter never exceeds WIN; width clog2(WIN+1).

Reset
REQ-028 INIT=0 asynchronously sets S = STATES/2, a_out = 0, cycle and ones counters = 0, win_count = 0, win_valid = 0.
REQ-029 INIT asserted mid-window discards partial window; no win_valid pulse generated for it.
REQ-030 First enabled edge after INIT release performs a normal update from S = STATES/2.

Structure
REQ-031 Package nn_node_pkg holds MODE constants (MODE_OR=0, MODE_SUM=1) and the signed-clamp function.
REQ-032 Sub-module nn_sat_counter (parametrised STATES, step width) implements REQ-021/022; top instantiates it once.
REQ-033 Window estimator stays inline in top level.

Verification (N=4, STATES=16, WIN=16)
REQ-034 INIT low mid-run -> S=8, a_out=0, win_count=0, win_valid=0 immediately, before next CLK edge.
REQ-035 MODE 0, a=alpha=4'hF, SIGN_alpha=0, beta=0, EN=1 -> S 9,10..15 then holds 15; a_out=1 from first edge.
REQ-036 MODE 1, a=alpha=4'hF, SIGN_alpha=4'hF, beta=1, SIGN_beta=1 -> step -5, S 3, 0, 0; a_out=0.
REQ-037 MODE 1, SIGN_alpha=4'b0011, a=alpha=4'hF, beta=0 -> step 0, S holds 8, a_out=1; MODE 0 same stimulus -> z=0, S holds 8.
REQ-038 Constant a_out=1, EN=1 for 16 cycles -> win_valid pulses once, win_count=16; EN toggling 50% -> pulse after 16 enabled edges (32 cycles).
REQ-039 INIT asserted after 10 enabled cycles of window -> no pulse; next pulse 16 enabled cycles after release.
